udm_split_bridge: RTL and testbench

Parametrised bridge between a single-phase master port (enable/ack, one transaction at a time) and a split-transaction bus (request/ack address phase, separate read response). Successor to the fixed 32-bit debug-bus splitter: configurable address/data width, byte enables passed from the master, optional write-response mode, a response timeout with error reporting, and registered bus-side outputs. It sits between the UART debug master (or any enable/ack master) and the system interconnect.

---
 rtl/udm_pkg.sv | 26 ++
 rtl/udm_timeout_cnt.sv | 28 ++
 rtl/udm_split_bridge.sv | 117 +++++++++++
 tb/tb_udm_split_bridge.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/udm_pkg.sv
// Shared types and elaboration-time helpers for the split-transaction debug bridge.
package udm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RESP,
    ST_DONE
  } udm_state_e;

  localparam int UDM_MAX_DATA_W = 1024;

  // Width that holds 0..timeout inclusive; a disabled timeout still gets one bit.
  function automatic int udm_cnt_w(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

  function automatic logic [UDM_MAX_DATA_W-1:0] udm_err_data(input int width);
    logic [UDM_MAX_DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < UDM_MAX_DATA_W; i++)
      if (i < width) d[i] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/udm_timeout_cnt.sv
// Wait-state watchdog: counts cycles while enabled, flags the TIMEOUT-th cycle.
module udm_timeout_cnt
  import udm_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int               CNT_W = udm_cnt_w(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)   cnt <= '0;
    else if (clr_i) cnt <= '0;
    else if (en_i)  cnt <= cnt + 1'b1;
  end

  // cnt holds the number of cycles already spent, so this is the last allowed one
  assign expired_o = en_i && (cnt == LAST);

endmodule

// File: rtl/udm_split_bridge.sv
// Enable/ack master to split-transaction bus bridge with optional write response and timeout.
module udm_split_bridge
  import udm_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WR_RESP = 0,
  parameter int TIMEOUT = 0
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                m_enb_i,
  input  logic                m_we_i,
  input  logic [ADDR_W-1:0]   m_addr_bi,
  input  logic [DATA_W/8-1:0] m_be_bi,
  input  logic [DATA_W-1:0]   m_wdata_bi,
  output logic                m_ack_o,
  output logic                m_err_o,
  output logic [DATA_W-1:0]   m_rdata_bo,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_bo,
  output logic [DATA_W/8-1:0] bus_be_bo,
  output logic [DATA_W-1:0]   bus_wdata_bo,
  input  logic                bus_ack_i,
  input  logic                bus_resp_i,
  input  logic [DATA_W-1:0]   bus_rdata_bi,
  output logic                busy_o
);

  localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(udm_err_data(DATA_W));

  udm_state_e state;
  logic       need_resp;
  logic       expired;

  assign need_resp = !bus_we_o || (WR_RESP != 0);
  assign busy_o    = (state != ST_IDLE);

  generate
    if (TIMEOUT > 0) begin : g_to
      logic to_clr, to_en;
      assign to_en  = (state == ST_REQ) || (state == ST_WAIT_RESP);
      assign to_clr = ((state == ST_IDLE) && m_enb_i) ||
                      ((state == ST_REQ) && bus_ack_i && need_resp && !bus_resp_i);
      udm_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_to (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expired_o(expired)
      );
    end else begin : g_no_to
      assign expired = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_IDLE;
      m_ack_o      <= 1'b0;
      m_err_o      <= 1'b0;
      m_rdata_bo   <= '0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_bo  <= '0;
      bus_be_bo    <= '0;
      bus_wdata_bo <= '0;
    end else begin
      m_ack_o <= 1'b0;
      m_err_o <= 1'b0;
      case (state)
        ST_IDLE: if (m_enb_i) begin
          bus_we_o     <= m_we_i;
          bus_addr_bo  <= m_addr_bi;
          bus_be_bo    <= m_be_bi;
          bus_wdata_bo <= m_wdata_bi;
          bus_req_o    <= 1'b1;
          state        <= ST_REQ;
        end
        ST_REQ: begin
          // A real bus exit in the expiry cycle takes priority over the timeout
          if (bus_ack_i) begin
            bus_req_o <= 1'b0;
            if (!need_resp || bus_resp_i) begin
              if (!bus_we_o) m_rdata_bo <= bus_rdata_bi;
              m_ack_o <= 1'b1;
              state   <= ST_DONE;
            end else begin
              state <= ST_WAIT_RESP;
            end
          end else if (expired) begin
            bus_req_o <= 1'b0;
            if (!bus_we_o) m_rdata_bo <= ERR_DATA;
            m_ack_o <= 1'b1;
            m_err_o <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_WAIT_RESP: begin
          if (bus_resp_i) begin
            if (!bus_we_o) m_rdata_bo <= bus_rdata_bi;
            m_ack_o <= 1'b1;
            state   <= ST_DONE;
          end else if (expired) begin
            if (!bus_we_o) m_rdata_bo <= ERR_DATA;
            m_ack_o <= 1'b1;
            m_err_o <= 1'b1;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udm_split_bridge.sv
// Directed bench: A (WR_RESP=0, TIMEOUT=8) and B (WR_RESP=1, no timeout) share stimulus; C is 16/64.
module tb_udm_split_bridge;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m_enb, m_we, bus_ack, bus_resp;
  logic [31:0] m_addr, m_wdata, bus_rdata;
  logic [3:0]  m_be;

  logic        a_ack, a_err, a_req, a_we, a_busy;
  logic [31:0] a_rdata, a_addr, a_wdata;
  logic [3:0]  a_be;
  logic        b_ack, b_err, b_req, b_we, b_busy;
  logic [31:0] b_rdata, b_addr, b_wdata;
  logic [3:0]  b_be;

  logic        c_enb, c_we, c_bus_ack, c_bus_resp;
  logic [15:0] c_addr;
  logic [7:0]  c_be;
  logic [63:0] c_wdata, c_bus_rdata;
  logic        c_ack, c_err, c_req, c_bwe, c_busy;
  logic [63:0] c_rdata, c_bwdata;
  logic [15:0] c_baddr;
  logic [7:0]  c_bbe;

  udm_split_bridge #(.WR_RESP(0), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .m_enb_i(m_enb), .m_we_i(m_we), .m_addr_bi(m_addr),
    .m_be_bi(m_be), .m_wdata_bi(m_wdata), .m_ack_o(a_ack), .m_err_o(a_err), .m_rdata_bo(a_rdata),
    .bus_req_o(a_req), .bus_we_o(a_we), .bus_addr_bo(a_addr), .bus_be_bo(a_be),
    .bus_wdata_bo(a_wdata), .bus_ack_i(bus_ack), .bus_resp_i(bus_resp),
    .bus_rdata_bi(bus_rdata), .busy_o(a_busy));

  udm_split_bridge #(.WR_RESP(1), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .m_enb_i(m_enb), .m_we_i(m_we), .m_addr_bi(m_addr),
    .m_be_bi(m_be), .m_wdata_bi(m_wdata), .m_ack_o(b_ack), .m_err_o(b_err), .m_rdata_bo(b_rdata),
    .bus_req_o(b_req), .bus_we_o(b_we), .bus_addr_bo(b_addr), .bus_be_bo(b_be),
    .bus_wdata_bo(b_wdata), .bus_ack_i(bus_ack), .bus_resp_i(bus_resp),
    .bus_rdata_bi(bus_rdata), .busy_o(b_busy));

  udm_split_bridge #(.ADDR_W(16), .DATA_W(64)) dut_c (
    .clk_i(clk), .rst_n_i(rst_n), .m_enb_i(c_enb), .m_we_i(c_we), .m_addr_bi(c_addr),
    .m_be_bi(c_be), .m_wdata_bi(c_wdata), .m_ack_o(c_ack), .m_err_o(c_err), .m_rdata_bo(c_rdata),
    .bus_req_o(c_req), .bus_we_o(c_bwe), .bus_addr_bo(c_baddr), .bus_be_bo(c_bbe),
    .bus_wdata_bo(c_bwdata), .bus_ack_i(c_bus_ack), .bus_resp_i(c_bus_resp),
    .bus_rdata_bi(c_bus_rdata), .busy_o(c_busy));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          ack_c;
    int          resp_c;
    logic [31:0] rdata;
    int          lat_a;
    int          lat_b;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[7];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int la, lb;
    logic [31:0] ra, rb;
    logic ea, eb;
    la = -1; lb = -1; ra = '0; rb = '0; ea = 1'b0; eb = 1'b0;
    for (int c = 0; c < 20 && (la < 0 || lb < 0); c++) begin
      @(negedge clk);
      if (c == 1) begin
        check({tag, "_req"}, 128'(a_req), 128'(1'b1));
        check({tag, "_fields"}, 128'({a_we, a_addr, a_be, a_wdata}),
              128'({v.we, v.addr, v.be, v.wdata}));
      end
      if (c == v.ack_c + 1) check({tag, "_req_drop"}, 128'(a_req), 128'(1'b0));
      if (a_ack && la < 0) begin la = c; ra = a_rdata; ea = a_err; end
      if (b_ack && lb < 0) begin lb = c; rb = b_rdata; eb = b_err; end
      m_enb = (la < 0); m_we = v.we; m_addr = v.addr; m_be = v.be; m_wdata = v.wdata;
      bus_ack = (c == v.ack_c); bus_resp = (c == v.resp_c); bus_rdata = v.rdata;
    end
    m_enb = 1'b0; bus_ack = 1'b0; bus_resp = 1'b0;
    check({tag, "_lat_a"}, 128'(la), 128'(v.lat_a));
    check({tag, "_lat_b"}, 128'(lb), 128'(v.lat_b));
    check({tag, "_rdata_a"}, 128'(ra), 128'(v.exp_rd));
    check({tag, "_rdata_b"}, 128'(rb), 128'(v.exp_rd));
    check({tag, "_err"}, 128'({ea, eb}), 128'(2'b00));
  endtask

  initial begin
    int la, stray, nack;
    logic ea;
    logic [31:0] ra;
    vec_t pr;
    m_enb = 0; m_we = 0; m_addr = 0; m_be = 0; m_wdata = 0;
    bus_ack = 0; bus_resp = 0; bus_rdata = 0;
    c_enb = 0; c_we = 0; c_addr = 0; c_be = 0; c_wdata = 0;
    c_bus_ack = 0; c_bus_resp = 0; c_bus_rdata = 0;
    rst_n = 1'b1;

    //            we addr          be     wdata         ack rsp rdata         latA latB exp_rd
    vecs[0] = '{1'b0, 32'h100, 4'hF, 32'h0,        1, 1, 32'hDEADBEEF, 2,  2,  32'hDEADBEEF};
    vecs[1] = '{1'b0, 32'h200, 4'hF, 32'h0,        3, 7, 32'h12345678, 8,  8,  32'h12345678};
    vecs[2] = '{1'b1, 32'h300, 4'h3, 32'hCAFEF00D, 1, 4, 32'hBAD0BAD0, 2,  5,  32'h12345678};
    vecs[3] = '{1'b1, 32'h304, 4'hC, 32'h0BADF00D, 2, 2, 32'hBAD0BAD0, 3,  3,  32'h12345678};
    vecs[4] = '{1'b0, 32'h308, 4'hF, 32'h0,        1, 2, 32'hA5A55A5A, 3,  3,  32'hA5A55A5A};
    vecs[5] = '{1'b0, 32'h30C, 4'hF, 32'h0,        8, 8, 32'h13572468, 9,  9,  32'h13572468};
    vecs[6] = '{1'b0, 32'h310, 4'hF, 32'h0,        1, 9, 32'h24681357, 10, 10, 32'h24681357};

    #2 rst_n = 1'b0;
    #1;
    check("reset_a", 128'({a_ack, a_err, a_rdata, a_req, a_we, a_addr, a_be, a_wdata, a_busy}), 128'(0));
    check("reset_c_data", 128'({c_ack, c_err, c_rdata, c_busy}), 128'(0));
    check("reset_c_bus", 128'({c_req, c_bwe, c_baddr, c_bbe, c_bwdata}), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Read with no bus ack: A times out after 8 request cycles, then stray responses
    la = -1; ea = 1'b0; ra = '0; stray = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c == 9) check("to_req_drop", 128'(a_req), 128'(1'b0));
      if (a_ack && la >= 0) stray++;
      if (a_ack && la < 0) begin la = c; ea = a_err; ra = a_rdata; end
      m_enb = (la < 0); m_we = 1'b0; m_addr = 32'h400; m_be = 4'hF;
      bus_ack = 1'b0; bus_resp = (c == 10 || c == 11); bus_rdata = 32'h55555555;
    end
    m_enb = 1'b0; bus_resp = 1'b0;
    check("to_lat", 128'(la), 128'(9));
    check("to_err", 128'(ea), 128'(1'b1));
    check("to_rdata", 128'(ra), 128'(32'hFFFFFFFF));
    check("to_stray_ack", 128'(stray), 128'(0));
    check("to_rdata_hold", 128'(a_rdata), 128'(32'hFFFFFFFF));
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Reset while both bridges wait for a read response
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      m_enb = 1'b1; m_we = 1'b0; m_addr = 32'h500; m_be = 4'hF;
      bus_ack = (c == 1); bus_resp = 1'b0; bus_rdata = 32'h77777777;
    end
    check("wait_busy", 128'({a_busy, a_req, b_busy, b_req}), 128'(4'b1010));
    rst_n = 1'b0; m_enb = 1'b0; bus_ack = 1'b0;
    #1;
    check("rst_mid_a", 128'({a_ack, a_err, a_rdata, a_req, a_we, a_addr, a_be, a_wdata, a_busy}), 128'(0));
    check("rst_mid_b", 128'({b_ack, b_err, b_rdata, b_req, b_we, b_addr, b_be, b_wdata, b_busy}), 128'(0));
    nack = 0;
    repeat (3) begin
      @(negedge clk);
      if (a_ack || b_ack) nack++;
    end
    check("rst_no_ack", 128'(nack), 128'(0));
    rst_n = 1'b1;
    pr = '{1'b0, 32'h600, 4'hF, 32'h0, 1, 1, 32'h600DF00D, 2, 2, 32'h600DF00D};
    run_txn(pr, "post_rst");

    // 16/64 bridge: request held, bus answers in the first request cycle
    nack = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 1) check("c_fields", 128'({c_req, c_baddr, c_bbe}), 128'({1'b1, 16'hBEEF, 8'hF0}));
      if (c_ack) begin
        check($sformatf("c_ack%0d_cycle", nack), 128'(c), 128'(2 + 3 * nack));
        check($sformatf("c_ack%0d_rdata", nack), 128'(c_rdata),
              128'(64'h1111_0000_0000_0000 | 64'(1 + 3 * nack)));
        nack++;
      end
      c_enb = (c < 9); c_we = 1'b0; c_addr = 16'hBEEF; c_be = 8'hF0;
      c_bus_ack = c_req; c_bus_resp = c_req;
      c_bus_rdata = 64'h1111_0000_0000_0000 | 64'(c);
    end
    c_enb = 1'b0; c_bus_ack = 1'b0; c_bus_resp = 1'b0;
    check("c_ack_count", 128'(nack), 128'(3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
